// File: rtl/adc_share_arbiter_if.sv
// Bundle of requester and ADC side signals for adc_share_arbiter.
//   master : arbiter view  (drives grant/done/adc_start/result*, timeout_err, busy)
//   slave  : environment view (drives req, adc_busy, adc_data)
interface adc_share_arbiter_if #(
    parameter int unsigned N_REQ = 6,
    parameter int unsigned ADC_W = 14
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             adc_start;
    logic             adc_busy;
    logic [ADC_W-1:0] adc_data;
    logic [ADC_W-1:0] result;
    logic             result_valid;
    logic [2:0]       result_id;
    logic             timeout_err;
    logic             busy;

    modport master (
        input  req, adc_busy, adc_data,
        output grant, done, adc_start, result, result_valid, result_id,
               timeout_err, busy
    );

    modport slave (
        output req, adc_busy, adc_data,
        input  grant, done, adc_start, result, result_valid, result_id,
               timeout_err, busy
    );
endinterface

// File: rtl/adc_share_arbiter.sv
// Round-robin arbiter and sequencer for the single shared ADC.
// Grants one requester, runs one conversion, returns the result tagged with
// the requester id and flags conversions that time out.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : adc_share_arbiter_if.master (req/grant/done, ADC handshake, result)
module adc_share_arbiter #(
    parameter int unsigned N_REQ   = 6,
    parameter int unsigned ADC_W   = 14,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    adc_share_arbiter_if.master bus
);
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_CONV,
        S_DONE,
        S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    winner_q, winner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               adc_start_q, adc_start_d;
    logic [ADC_W-1:0]   result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [ID_W-1:0]    result_id_q, result_id_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;

    // First asserted request at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!pick_found && bus.req[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state and registered-output logic. Pulsed outputs are computed on
    // the transition so they are visible during the state they belong to.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        winner_d       = winner_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        done_d         = '0;
        adc_start_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        timeout_err_d  = timeout_err_q;

        unique case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_found) begin
                    winner_d = pick_idx;
                    grant_d  = N_REQ'(1) << pick_idx;
                    ptr_d    = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
                    state_d  = S_START;
                end
            end
            S_START: begin
                // adc_busy is deliberately not looked at here: it may be stale.
                adc_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.adc_busy) begin
                    state_d = S_CONV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d       = S_ABORT;
                        done_d        = grant_q;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            S_CONV: begin
                if (!bus.adc_busy) begin
                    result_d       = bus.adc_data;
                    result_valid_d = 1'b1;
                    result_id_d    = winner_q;
                    done_d         = grant_q;
                    state_d        = S_DONE;
                end else begin
                    // Counter carries over from WAIT_BUSY: one budget per conversion.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d       = S_ABORT;
                        done_d        = grant_q;
                        timeout_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            winner_q       <= '0;
            cnt_q          <= '0;
            grant_q        <= '0;
            done_q         <= '0;
            adc_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            winner_q       <= winner_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            done_q         <= done_d;
            adc_start_q    <= adc_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.adc_start    = adc_start_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result_id    = result_id_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_adc_share_arbiter.sv
// Self-checking bench for adc_share_arbiter with a behavioural ADC model and
// a round-robin reference model.
module tb_adc_share_arbiter;
    localparam int unsigned N  = 6;
    localparam int unsigned W  = 14;
    localparam int unsigned TO = 255;

    typedef enum int {M_NORMAL, M_NEVER, M_STUCK} mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] req_r      = '0;
    logic [W-1:0] data_r     = '0;
    logic         adc_busy_m = 1'b0;

    adc_share_arbiter_if #(.N_REQ(N), .ADC_W(W)) bus ();
    assign bus.req      = req_r;
    assign bus.adc_data = data_r;
    assign bus.adc_busy = adc_busy_m;

    adc_share_arbiter #(.N_REQ(N), .ADC_W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           tests       = 0;
    int           fails       = 0;
    int           ptr_m       = 0;
    logic [W-1:0] last_res    = '0;
    int           n_starts    = 0;
    int           onehot_viol = 0;
    int           start_dbl   = 0;
    logic         prev_start  = 1'b0;
    mode_t        mode        = M_NORMAL;
    int           conv_c      = 20;
    int           remaining   = 0;
    bit           arm         = 1'b0;

    // ADC model: busy rises the cycle after adc_start and stays high conv_c cycles.
    always @(negedge clk) begin
        if (arm) begin
            arm = 1'b0;
            if (mode != M_NEVER) begin
                adc_busy_m = 1'b1;
                remaining  = (mode == M_STUCK) ? 1 : conv_c;
            end
        end else if (adc_busy_m && mode != M_STUCK) begin
            remaining = remaining - 1;
            if (remaining <= 0) adc_busy_m = 1'b0;
        end
        if (bus.adc_start === 1'b1) begin
            arm      = 1'b1;
            n_starts = n_starts + 1;
        end
        if (!rst) begin
            if (!$onehot0(bus.grant)) onehot_viol = onehot_viol + 1;
            if (bus.adc_start === 1'b1 && prev_start) start_dbl = start_dbl + 1;
        end
        prev_start = bus.adc_start;
    end

    // Round-robin rule: first set bit scanning from p upward, modulo N.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (p + k) % int'(N);
            if (r[j]) return j;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [N-1:0] g);
        for (int k = 0; k < int'(N); k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.grant != '0) begin
                idx = idx_of(bus.grant);
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_r = '0;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        ptr_m    = 0;
        last_res = '0;
    endtask

    task automatic test_reset();
        logic [32:0] v;
        repeat (2) @(negedge clk);
        v = {bus.grant, bus.done, bus.adc_start, bus.result, bus.result_valid,
             bus.result_id, bus.timeout_err, bus.busy};
        tests++;
        if (v !== '0) begin fails++; $display("FAIL reset_in got %h want 0", v); end
        rst = 1'b0;
        @(negedge clk);
        v = {bus.grant, bus.done, bus.adc_start, bus.result, bus.result_valid,
             bus.result_id, bus.timeout_err, bus.busy};
        tests++;
        if (v !== '0) begin fails++; $display("FAIL reset_after got %h want 0", v); end
    endtask

    task automatic test_single();
        int cyc, s0, exp;
        mode = M_NORMAL; conv_c = 20; data_r = 14'h1A5; s0 = n_starts;
        req_r = 6'b000100;
        exp = pick(req_r, ptr_m);
        ptr_m = (exp + 1) % int'(N);
        @(negedge clk);
        tests++;
        if (bus.grant !== 6'b000100 || bus.busy !== 1'b1) begin
            fails++; $display("FAIL single_grant got %b busy %b want 000100 busy 1", bus.grant, bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.adc_start !== 1'b1) begin fails++; $display("FAIL single_start got %b want 1", bus.adc_start); end
        wait_done(60, cyc);
        tests++;
        if (cyc != conv_c + 2) begin fails++; $display("FAIL single_latency got %0d want %0d", cyc, conv_c + 2); end
        tests++;
        if ({bus.done, bus.result_valid, bus.result, bus.result_id, bus.grant} !==
            {6'b000100, 1'b1, 14'h1A5, 3'd2, 6'b000100}) begin
            fails++;
            $display("FAIL single_result got done %b rv %b res %h id %0d grant %b want 000100 1 1a5 2 000100",
                     bus.done, bus.result_valid, bus.result, bus.result_id, bus.grant);
        end
        last_res = 14'h1A5;
        req_r = '0;
        @(negedge clk);
        tests++;
        if ({bus.grant, bus.done, bus.result_valid, bus.busy} !== '0) begin
            fails++; $display("FAIL single_idle got grant %b done %b rv %b busy %b want zeros",
                              bus.grant, bus.done, bus.result_valid, bus.busy);
        end
        tests++;
        if (n_starts - s0 != 1) begin fails++; $display("FAIL single_starts got %0d want 1", n_starts - s0); end
    endtask

    // Requesters hold their bits and re-request at done; covers both the
    // fixed all-ones case and random traffic.
    task automatic run_services(input string tag, input int n, input bit rnd);
        int idx, exp, cyc, s0;
        logic [N-1:0] one;
        s0 = n_starts;
        conv_c = $urandom_range(1, 8);
        data_r = W'($urandom);
        for (int k = 0; k < n; k++) begin
            exp = pick(req_r, ptr_m);
            wait_grant(idx);
            tests++;
            if (idx != exp) begin fails++; $display("FAIL %s_order[%0d] got %0d want %0d", tag, k, idx, exp); end
            ptr_m = (exp + 1) % int'(N);
            one = N'(1) << exp;
            wait_done(40, cyc);
            tests++;
            if (cyc != conv_c + 3 || bus.done !== one || bus.result_valid !== 1'b1 ||
                bus.result !== data_r || bus.result_id !== 3'(exp)) begin
                fails++;
                $display("FAIL %s_svc[%0d] got cyc %0d done %b res %h id %0d want cyc %0d done %b res %h id %0d",
                         tag, k, cyc, bus.done, bus.result, bus.result_id, conv_c + 3, one, data_r, exp);
            end
            last_res = data_r;
            conv_c = $urandom_range(1, 8);
            data_r = W'($urandom);
            if (rnd) begin
                req_r = (req_r & ~one) | (N'($urandom) & N'($urandom));
                if (req_r == '0) req_r = N'($urandom_range(1, (1 << N) - 1));
            end
            if (k == n - 1) req_r = '0;
        end
        @(negedge clk);
        tests++;
        if (n_starts - s0 != n) begin fails++; $display("FAIL %s_starts got %0d want %0d", tag, n_starts - s0, n); end
    endtask

    task automatic test_all_held();
        do_reset();
        req_r = '1;
        run_services("all", 12, 1'b0);
    endtask

    task automatic test_wrap();
        logic [N-1:0] seq [3];
        int idx, exp, cyc;
        seq[0] = 6'b100000; seq[1] = 6'b100001; seq[2] = 6'b100000;
        req_r = seq[0];
        for (int k = 0; k < 3; k++) begin
            exp = pick(req_r, ptr_m);
            wait_grant(idx);
            tests++;
            if (idx != exp) begin fails++; $display("FAIL wrap_order[%0d] got %0d want %0d", k, idx, exp); end
            ptr_m = (exp + 1) % int'(N);
            wait_done(40, cyc);
            last_res = data_r;
            req_r = (k < 2) ? seq[k + 1] : '0;
        end
    endtask

    task automatic test_timeout();
        int idx, exp, cyc;
        logic [N-1:0] one;
        for (int ph = 0; ph < 2; ph++) begin
            mode  = (ph == 0) ? M_NEVER : M_STUCK;
            req_r = (ph == 0) ? 6'b000010 : 6'b010000;
            exp = pick(req_r, ptr_m);
            wait_grant(idx);
            ptr_m = (exp + 1) % int'(N);
            one = N'(1) << exp;
            @(negedge clk);
            // Stuck busy rises a cycle after start, so one counted cycle is spent waiting.
            wait_done(TO + 20, cyc);
            tests++;
            if (cyc != int'(TO) + ph) begin fails++; $display("FAIL timeout%0d_latency got %0d want %0d", ph, cyc, int'(TO) + ph); end
            tests++;
            if (bus.done !== one || bus.result_valid !== 1'b0 || bus.result !== last_res || bus.timeout_err !== 1'b1) begin
                fails++;
                $display("FAIL timeout%0d_abort got done %b rv %b res %h err %b want %b 0 %h 1",
                         ph, bus.done, bus.result_valid, bus.result, bus.timeout_err, one, last_res);
            end
            req_r = '0;
            mode  = M_NORMAL;
            repeat (4) @(negedge clk);
            tests++;
            if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL timeout%0d_sticky got err %b busy %b want 1 0", ph, bus.timeout_err, bus.busy);
            end
        end
        req_r = 6'b001000;
        run_services("after_to", 1, 1'b0);
        tests++;
        if (bus.timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_persist got %b want 1", bus.timeout_err); end
    endtask

    task automatic test_reset_mid();
        int idx, s0, dseen;
        logic [32:0] v;
        mode = M_NORMAL; conv_c = 20;
        req_r = 6'b000100;
        wait_grant(idx);
        @(negedge clk);
        repeat (6) @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== '0) begin
            fails++; $display("FAIL rstmid_conv got busy %b done %b want 1 0", bus.busy, bus.done);
        end
        rst = 1'b1; req_r = '0;
        @(negedge clk);
        v = {bus.grant, bus.done, bus.adc_start, bus.result, bus.result_valid,
             bus.result_id, bus.timeout_err, bus.busy};
        tests++;
        if (v !== '0) begin fails++; $display("FAIL rstmid_outputs got %h want 0", v); end
        rst = 1'b0; ptr_m = 0; last_res = '0;
        s0 = n_starts; dseen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done != '0) dseen++;
        end
        tests++;
        if (n_starts != s0 || dseen != 0) begin
            fails++; $display("FAIL rstmid_quiet got starts %0d dones %0d want 0 0", n_starts - s0, dseen);
        end
        // Bits 1 and 3 pending: a cleared pointer serves 1 first.
        req_r = 6'b001010;
        run_services("rstmid_post", 2, 1'b1);
    endtask

    task automatic test_early_drop();
        int idx, cyc;
        mode = M_NORMAL; conv_c = 6; data_r = W'($urandom);
        req_r = 6'b001000;
        wait_grant(idx);
        ptr_m = (idx + 1) % int'(N);
        @(negedge clk);
        req_r = '0;
        wait_done(40, cyc);
        tests++;
        if (cyc != conv_c + 2 || bus.done !== 6'b001000 || bus.result_valid !== 1'b1 || bus.result !== data_r) begin
            fails++;
            $display("FAIL drop_done got cyc %0d done %b rv %b res %h want %0d 001000 1 %h",
                     cyc, bus.done, bus.result_valid, bus.result, conv_c + 2, data_r);
        end
        last_res = data_r;
        @(negedge clk);
        tests++;
        if (bus.grant !== '0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL drop_release got grant %b busy %b want 0 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_random();
        req_r = N'($urandom_range(1, (1 << N) - 1));
        run_services("rand", 25, 1'b1);
    endtask

    task automatic test_invariants();
        tests++;
        if (onehot_viol != 0) begin fails++; $display("FAIL grant_onehot got %0d violations want 0", onehot_viol); end
        tests++;
        if (start_dbl != 0) begin fails++; $display("FAIL start_pulse got %0d double pulses want 0", start_dbl); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_held();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_early_drop();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adc_share_arbiter.md
Name: adc_share_arbiter

Overview:
- Round-robin arbiter and sequencer for the single shared ADC.
- Sits between the per-device operation blocks (requesters, selected by dev_cs) and the ADC interface.
- Grants one requester at a time, runs one conversion, returns the 14-bit result tagged with the requester id, and flags conversions that time out.

Parameters:
N_REQ, 6, number of requesters (supported range 2..8).
ADC_W, 14, ADC result width.
TIMEOUT, 255, max cycles allowed in WAIT_BUSY or CONV before abort (8-bit counter).

Ports:
clk  in  1  system clock.
rst  in  1  reset: synchronous, active-high. Clock is clk.
req  in  N_REQ  level requests; bit i is held high until done[i].
grant  out  N_REQ  one-hot grant; all zero when idle.
done  out  N_REQ  one-cycle pulse to the granted requester at end of service.
adc_start  out  1  one-cycle conversion start pulse.
adc_busy  in  1  high while the ADC converts.
adc_data  in  ADC_W  ADC result, valid once adc_busy falls.
result  out  ADC_W  captured result.
result_valid  out  1  one-cycle strobe, coincident with done.
result_id  out  3  index of the requester that owns result.
timeout_err  out  1  sticky; set on any timeout, cleared only by rst.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: grant=0, done=0, adc_start=0, result=0, result_valid=0, result_id=0, timeout_err=0, busy=0, priority pointer=0, state=IDLE, timeout counter=0.
- Reset has priority over all other logic and aborts any operation in progress. adc_start must not pulse in the cycle after rst.
- Arbitration:
  - Search order starts at index ptr and wraps modulo N_REQ. The first req bit found wins.
  - On grant, ptr <= (winner+1) mod N_REQ.
  - ptr stays unchanged when no request is present.
- States:
  - IDLE: if req!=0, latch winner, set grant one-hot, busy=1, go to START. Otherwise stay.
  - START: adc_start=1 for exactly one cycle, clear timeout counter, go to WAIT_BUSY.
  - WAIT_BUSY: if adc_busy=1, go to CONV. Else increment counter; when counter==TIMEOUT, go to ABORT.
  - CONV: if adc_busy=0, result<=adc_data, go to DONE. Else increment counter; when counter==TIMEOUT, go to ABORT.
  - DONE: done[winner]=1, result_valid=1, result_id=winner, grant still asserted this cycle. Go to IDLE; grant=0 next cycle.
  - ABORT: timeout_err<=1, done[winner]=1, result_valid=0, result unchanged. Go to IDLE.
- Latency with no contention and adc_busy high for C cycles starting the cycle after adc_start:
  - req rise to grant: 1 cycle.
  - grant to adc_start: 1 cycle.
  - result_valid follows the adc_busy fall by 1 cycle.
- A requester that drops req after being granted does not abort service. The conversion completes and done still pulses.
- A requester that keeps req high in the done cycle is treated as a new request. It is eligible in the next IDLE cycle but has the lowest priority because ptr has already advanced.
- In IDLE, new requests are evaluated every cycle; no idle bubble is added beyond the DONE→IDLE cycle.
- adc_busy already high in START (stale busy from a previous conversion) is ignored; it is sampled only from WAIT_BUSY on.
- Requests on bits ≥ N_REQ do not exist. result_id is zero-extended to 3 bits.
- grant is at most one-hot in every cycle. Formal/assert check: $onehot0(grant).

Test Plan:
1. Single request: req=6'b000100, ADC model busy 20 cycles, data 14'h1A5 -> grant=000100, one adc_start, result=14'h1A5, result_id=2, done[2] and result_valid pulse together 1 cycle after busy falls.
2. All requests held: req=6'b111111 for 12 services -> grant order 0,1,2,3,4,5,0,1,2,3,4,5; exactly one adc_start per grant.
3. Fairness after wrap: serve index 5, then req=6'b100001 -> index 0 served before index 5.
4. Timeout: ADC never raises busy -> after TIMEOUT cycles in WAIT_BUSY, done pulses with result_valid=0, timeout_err stays 1, next request is served normally. Repeat with busy stuck high in CONV.
5. Reset mid-conversion: assert rst in CONV cycle 5 -> next cycle all outputs at reset values, ptr=0, no done, no spurious adc_start; a subsequent req=000010 is served normally.
6. Early drop: req[3] deasserted in the cycle after grant -> conversion completes, done[3] and result_valid still pulse, grant returns to 0.
